// File: rtl/sha3_pkg.sv
// sha3_pkg: constants and types shared by the SHA3 padder and its helpers.
//   RATE_WORDS      32-bit words per absorb block (576-bit rate, SHA3-512)
//   DOMAIN_BYTE     SHA3 domain-separation byte appended after the message
//   FINAL_BIT_MASK  bit ORed into the last byte of the final padded block
//   pad_state_t     padder control states
package sha3_pkg;

  localparam int         RATE_WORDS     = 18;
  localparam logic [7:0] DOMAIN_BYTE    = 8'h06;
  localparam logic [7:0] FINAL_BIT_MASK = 8'h80;

  typedef enum logic [1:0] {
    ABSORB    = 2'd0,
    PAD       = 2'd1,
    FULL      = 2'd2,
    FULL_LAST = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: combinational formatter for the word written into the block
// buffer on each shift.
//   in          raw message word, byte 0 in in[31:24]
//   byte_num    valid bytes in the final word (0..3)
//   is_last     in is the final message word
//   pad_active  padder is filling the block with zero words
//   word        word to store
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [31:0] in,
  input  logic [1:0]  byte_num,
  input  logic        is_last,
  input  logic        pad_active,
  output logic [31:0] word
);

  // Padding fill wins over everything; a final word keeps its valid bytes,
  // gets the domain byte right after them and zeros below.
  always_comb begin
    word = in;
    if (pad_active) begin
      word = '0;
    end else if (is_last) begin
      case (byte_num)
        2'd0:    word = {DOMAIN_BYTE, 24'h000000};
        2'd1:    word = {in[31:24], DOMAIN_BYTE, 16'h0000};
        2'd2:    word = {in[31:16], DOMAIN_BYTE, 8'h00};
        default: word = {in[31:8], DOMAIN_BYTE};
      endcase
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// sha3_padder: collects 32-bit message words into a RATE_WORDS-word block,
// applies SHA3 padding (0x06 ... 0x80) after the final word and hands the
// block to the permutation core.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in           message word, byte 0 in in[31:24]
//   in_ready     in is valid this cycle
//   is_last      in is the final message word
//   byte_num     valid bytes in the final word (0..3)
//   buffer_full  block buffer full, upstream must hold off
//   out          padded block, word 0 in the top 32 bits
//   out_ready    out holds a complete block
//   f_ack        permutation core has consumed out
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = sha3_pkg::RATE_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [1:0]              byte_num,
  output logic                    buffer_full,
  output logic [32*RATE_WORDS-1:0] out,
  output logic                    out_ready,
  input  logic                    f_ack
);

  localparam int         OUT_W    = 32 * RATE_WORDS;
  localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

  pad_state_t       state, state_next;
  logic [4:0]       count;
  logic             pad_flag;
  logic [OUT_W-1:0] buffer;

  logic        accept_word;
  logic        accept_last;
  logic        shift_en;
  logic        final_word;
  logic        block_done;
  logic [31:0] fmt_word;
  logic [31:0] store_word;

  assign accept_word = (state == ABSORB) && in_ready;
  assign accept_last = accept_word && is_last;
  assign shift_en    = accept_word || (state == PAD);
  assign block_done  = (state == FULL) || (state == FULL_LAST);

  // The word that closes a padded block carries the trailing 0x80 bit; when
  // the final message word itself closes the block this merges with 0x06.
  assign final_word = shift_en && (count == LAST_IDX) &&
                      (accept_last || ((state == PAD) && pad_flag));
  assign store_word = final_word ? (fmt_word | {24'h000000, FINAL_BIT_MASK})
                                 : fmt_word;

  sha3_pad_word u_pad_word (
    .in         (in),
    .byte_num   (byte_num),
    .is_last    (is_last),
    .pad_active (state == PAD),
    .word       (fmt_word)
  );

  // Next-state logic: a block closes on the word that brings the counter to
  // RATE_WORDS; full states wait for the core's acknowledge.
  always_comb begin
    state_next = state;
    case (state)
      ABSORB: begin
        if (in_ready) begin
          if (count == LAST_IDX) begin
            state_next = is_last ? FULL_LAST : FULL;
          end else if (is_last) begin
            state_next = PAD;
          end
        end
      end
      PAD: begin
        if (count == LAST_IDX) begin
          state_next = pad_flag ? FULL_LAST : FULL;
        end
      end
      FULL, FULL_LAST: begin
        if (f_ack) begin
          state_next = ABSORB;
        end
      end
      default: state_next = ABSORB;
    endcase
  end

  // State, word counter, padding flag and the shifting block buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ABSORB;
      count    <= '0;
      pad_flag <= 1'b0;
      buffer   <= '0;
    end else begin
      state <= state_next;
      if (shift_en) begin
        buffer <= {buffer[OUT_W-33:0], store_word};
        count  <= count + 5'd1;
      end else if (block_done && f_ack) begin
        count <= '0;
      end
      if (accept_last) begin
        pad_flag <= 1'b1;
      end else if ((state == FULL_LAST) && f_ack) begin
        pad_flag <= 1'b0;
      end
    end
  end

  assign buffer_full = block_done;
  assign out_ready   = block_done;
  assign out         = buffer;

endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder: randomized scoreboard bench for sha3_padder. A byte-level
// reference model builds each expected block from the message bytes and the
// SHA3 padding rule; a monitor pops and compares when out_ready rises.
module tb_sha3_padder;

  localparam int R     = 18;
  localparam int OUT_W = 32 * R;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             is_last;
  logic [1:0]       byte_num;
  logic             buffer_full;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;
  logic             f_ack;

  exp_t       sb[$];
  logic [7:0] blk_bytes[$];
  int         blk_words   = 0;
  int         edge_cnt    = 0;
  int         checks      = 0;
  int         failures    = 0;
  bit         pad_pending = 0;
  bit         last_open   = 0;
  int         last_edge   = 0;

  sha3_padder #(.RATE_WORDS(R)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_data),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out_data),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge index; drivers read it 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [OUT_W-1:0] act,
                             input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Close the current model block and queue it with its expected edge.
  task automatic pushBlock(input int due);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < R * 4; i++) e.data[OUT_W-1-8*i -: 8] = blk_bytes[i];
    e.due = due;
    sb.push_back(e);
    blk_bytes.delete();
    blk_words = 0;
  endtask

  // Drive one message word once the padder can take it, then update the model.
  task automatic applyStimulus(input logic [31:0] w, input bit last,
                               input logic [1:0] bn);
    int guard = 0;
    int t;
    int k;
    forever begin
      if (pad_pending && buffer_full) pad_pending = 0;
      if (!buffer_full && !pad_pending) break;
      // Junk traffic while busy must be ignored by the padder.
      in_ready = 1'b1;
      in_data  = $urandom;
      is_last  = 1'($urandom_range(0, 1));
      byte_num = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout got=busy expected=ready");
        in_ready = 1'b0;
        return;
      end
    end
    repeat ($urandom_range(0, 1)) begin
      in_ready = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = w;
    in_ready = 1'b1;
    is_last  = last;
    byte_num = bn;
    @(posedge clk); #1;
    in_ready = 1'b0;
    is_last  = 1'b0;
    t = edge_cnt;
    if (!last) begin
      for (int b = 0; b < 4; b++) blk_bytes.push_back(w[31-8*b -: 8]);
      blk_words++;
      if (blk_words == R) pushBlock(t);
    end else begin
      k = blk_words;
      for (int b = 0; b < int'(bn); b++) blk_bytes.push_back(w[31-8*b -: 8]);
      blk_bytes.push_back(8'h06);
      while (blk_bytes.size() < R * 4) blk_bytes.push_back(8'h00);
      blk_bytes[R*4-1] = blk_bytes[R*4-1] | 8'h80;
      pushBlock(t + (R - 1 - k));
      pad_pending = 1;
      last_open   = 1;
      last_edge   = t;
    end
  endtask

  // Acknowledge: hold off 5 cycles on the first block, random later; also
  // spurious pulses while no block is presented.
  initial begin
    int ack_wait = 5;
    f_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset || f_ack) begin
        f_ack = 1'b0;
      end else if (out_ready) begin
        if (ack_wait == 0) begin
          f_ack    = 1'b1;
          ack_wait = $urandom_range(0, 4);
        end else begin
          ack_wait--;
        end
      end else begin
        f_ack = ($urandom_range(0, 9) == 0);
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    bit               prev_ready = 0;
    bit               ack_pend   = 0;
    logic [OUT_W-1:0] held       = '0;
    exp_t             cur;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("reset_out_ready", OUT_W'(out_ready), OUT_W'(0));
        checkOutput("reset_buffer_full", OUT_W'(buffer_full), OUT_W'(0));
        checkOutput("reset_out", out_data, '0);
        prev_ready = 0;
        ack_pend   = 0;
      end else begin
        if (ack_pend) checkOutput("ack_release", OUT_W'(out_ready), OUT_W'(0));
        if (out_ready) begin
          checkOutput("buffer_full", OUT_W'(buffer_full), OUT_W'(1));
          if (!prev_ready) begin
            last_open = 0;
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_block got=out_ready expected=idle");
            end else begin
              cur = sb.pop_front();
              checkOutput("block_data", out_data, cur.data);
              checkOutput("block_latency", OUT_W'(edge_cnt), OUT_W'(cur.due));
            end
            held = out_data;
          end else begin
            checkOutput("block_stable", out_data, held);
          end
        end else begin
          checkOutput("buffer_full_idle", OUT_W'(buffer_full), OUT_W'(0));
        end
        if (last_open) begin
          checks++;
          lat_bound: assert (edge_cnt - last_edge <= R) else begin
            failures++;
            $display("[TB] FAIL last_to_ready got=%0d expected<=%0d",
                     edge_cnt - last_edge, R);
            last_open = 0;
          end
        end
        ack_pend   = out_ready && f_ack;
        prev_ready = out_ready;
      end
    end
  end

  initial begin
    int guard;
    int len;
    reset    = 1'b0;
    in_data  = '0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] block of counting words");
    for (int i = 0; i < R; i++) applyStimulus(32'(i), 1'b0, 2'd0);

    $display("[TB] is_last at word 0");
    applyStimulus(32'hAABBCCDD, 1'b1, 2'd2);

    $display("[TB] is_last at word 17");
    for (int i = 0; i < R - 1; i++) applyStimulus($urandom, 1'b0, 2'd0);
    applyStimulus(32'h11223344, 1'b1, 2'd3);

    $display("[TB] reset mid-block");
    for (int i = 0; i < 9; i++) applyStimulus($urandom, 1'b0, 2'd0);
    reset    = 1'b0;
    in_ready = 1'b0;
    blk_bytes.delete();
    blk_words   = 0;
    pad_pending = 0;
    last_open   = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < R; i++) applyStimulus($urandom, 1'b0, 2'd0);

    $display("[TB] random messages");
    for (int m = 0; m < 12; m++) begin
      len = $urandom_range(0, 160);
      for (int i = 0; i < len / 4; i++) applyStimulus($urandom, 1'b0, 2'd0);
      applyStimulus($urandom, 1'b1, 2'(len % 4));
    end

    guard = 0;
    while ((sb.size() != 0 || out_ready) && guard < 600) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 600) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout got=%0d pending expected=0", sb.size());
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
